// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared constants, state encodings and packing helpers for the pixel packer
package fb_pkg;

    localparam int FB_DATA_WIDTH  = 32;
    localparam int FB_PIX_WIDTH   = 24;
    localparam int FB_FRAME_WORDS = 230400;
    localparam int FB_FIFO_DEPTH  = 4;
    localparam int CNT_W          = 18;

    // Frame-buffer handshake strobes are active-low.
    localparam logic FB_ASSERT   = 1'b0;
    localparam logic FB_DEASSERT = 1'b1;

    typedef enum logic [1:0] {
        ST_WAIT_SOF = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_DRAIN    = 2'd2
    } fb_state_e;

    // Word completed by the pixel arriving in the given phase; phase 0 completes nothing.
    function automatic logic [FB_DATA_WIDTH-1:0] pack_word(
        input logic [1:0]              phase,
        input logic [FB_PIX_WIDTH-1:0] residue,
        input logic [FB_PIX_WIDTH-1:0] pix
    );
        case (phase)
            2'd1:    return {pix[7:0], residue};
            2'd2:    return {pix[15:0], residue[15:0]};
            2'd3:    return {pix, residue[7:0]};
            default: return '0;
        endcase
    endfunction

    // Bytes of the current pixel still waiting for a word after this phase.
    function automatic logic [FB_PIX_WIDTH-1:0] next_residue(
        input logic [1:0]              phase,
        input logic [FB_PIX_WIDTH-1:0] pix
    );
        case (phase)
            2'd0:    return pix;
            2'd1:    return {8'h00, pix[23:8]};
            2'd2:    return {16'h0000, pix[23:16]};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/pix_word_fifo.sv
// rtl/pix_word_fifo.sv - synchronous word FIFO with registered head and occupancy count
module pix_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       wr_clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    rd_next;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             pop_ok;
    logic             push_ok;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        pop_ok  = pop_i && (count_q != '0);
        push_ok = push_i && ((count_q != FULL_C) || pop_ok);
        rd_next = rd_ptr_q + AW'(1);
    end

    // Pointer, occupancy and head-register next state; flush wins over everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            head_d   = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_next;
            end
            case ({push_ok, pop_ok})
                2'b10: begin
                    count_d = count_q + ONE_C;
                    if (count_q == '0) begin
                        head_d = push_data_i;
                    end
                end
                2'b01: begin
                    count_d = count_q - ONE_C;
                    head_d  = (count_q == ONE_C) ? '0 : mem_q[rd_next];
                end
                2'b11: begin
                    head_d = (count_q == ONE_C) ? push_data_i : mem_q[rd_next];
                end
                default: ;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge wr_clk) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Control registers.
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/pixel_packer.sv
// rtl/pixel_packer.sv - packs RGB888 pixels into 32-bit frame-buffer words
module pixel_packer
    import fb_pkg::*;
#(
    parameter int DATA_WIDTH  = FB_DATA_WIDTH,
    parameter int PIX_WIDTH   = FB_PIX_WIDTH,
    parameter int FRAME_WORDS = FB_FRAME_WORDS,
    parameter int FIFO_DEPTH  = FB_FIFO_DEPTH
) (
    input  logic                  wr_clk,
    input  logic                  reset,
    input  logic                  sof,
    input  logic                  pix_valid,
    input  logic [PIX_WIDTH-1:0]  pix_data,
    output logic                  fb_wr_en_in,
    output logic [DATA_WIDTH-1:0] fb_wr_data,
    input  logic                  fb_wr_en,
    input  logic                  fb_wr_rdy,
    output logic [CNT_W-1:0]      word_count,
    output logic                  frame_done,
    output logic                  overflow,
    output logic                  sof_err
);

    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [FCW-1:0]   FIFO_FULL_C = FCW'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FW_C        = CNT_W'(FRAME_WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE_C   = CNT_W'(1);

    fb_state_e             state_q, state_d;
    logic [1:0]            phase_q, phase_d;
    logic [PIX_WIDTH-1:0]  residue_q, residue_d;
    logic [CNT_W-1:0]      prod_q, prod_d;
    logic [CNT_W-1:0]      wc_q, wc_d;
    logic                  frame_done_q, frame_done_d;
    logic                  overflow_q, overflow_d;
    logic                  sof_err_q, sof_err_d;

    logic [FCW-1:0]        fifo_count;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  pop;
    logic                  pix_take;
    logic                  makes_word;
    logic                  push;
    logic                  pix_drop;
    logic                  pix_adv;
    logic [DATA_WIDTH-1:0] word;
    logic [CNT_W-1:0]      prod_next;

    // Handshake and pixel-acceptance decode; a pixel alongside sof is discarded.
    always_comb begin
        fifo_empty = (fifo_count == '0);
        fifo_full  = (fifo_count == FIFO_FULL_C);
        pop        = !fifo_empty && (fb_wr_en == FB_ASSERT) && fb_wr_rdy;
        pix_take   = (state_q == ST_ACTIVE) && pix_valid && !sof;
        makes_word = (phase_q != 2'd0);
        push       = pix_take && makes_word && (!fifo_full || pop);
        pix_drop   = pix_take && makes_word && fifo_full && !pop;
        pix_adv    = pix_take && !pix_drop;
        word       = pack_word(phase_q, residue_q, pix_data);
        prod_next  = prod_q + CNT_ONE_C;
    end

    // Frame FSM next state plus packing, counting and status updates.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        residue_d    = residue_q;
        prod_d       = prod_q;
        wc_d         = wc_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        sof_err_d    = sof_err_q;
        if (sof) begin
            state_d   = ST_ACTIVE;
            phase_d   = 2'd0;
            residue_d = '0;
            prod_d    = '0;
            wc_d      = '0;
            if (state_q != ST_WAIT_SOF) begin
                sof_err_d = 1'b1;
            end
        end else begin
            if (pop && (wc_q != FW_C)) begin
                wc_d = wc_q + CNT_ONE_C;
            end
            case (state_q)
                ST_WAIT_SOF: ;
                ST_ACTIVE: begin
                    if (pix_drop) begin
                        overflow_d = 1'b1;
                    end
                    if (pix_adv) begin
                        phase_d   = phase_q + 2'd1;
                        residue_d = next_residue(phase_q, pix_data);
                    end
                    if (push) begin
                        prod_d = prod_next;
                        if (prod_next == FW_C) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if ((wc_q == FW_C) && fifo_empty) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_WAIT_SOF;
                    end
                end
                default: state_d = ST_WAIT_SOF;
            endcase
        end
    end

    // State and status registers.
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            state_q      <= ST_WAIT_SOF;
            phase_q      <= 2'd0;
            residue_q    <= '0;
            prod_q       <= '0;
            wc_q         <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            residue_q    <= residue_d;
            prod_q       <= prod_d;
            wc_q         <= wc_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            sof_err_q    <= sof_err_d;
        end
    end

    pix_word_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .wr_clk      (wr_clk),
        .reset       (reset),
        .flush_i     (sof),
        .push_i      (push),
        .push_data_i (word),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    assign fb_wr_en_in = fifo_empty ? FB_DEASSERT : FB_ASSERT;
    assign fb_wr_data  = fifo_head;
    assign word_count  = wc_q;
    assign frame_done  = frame_done_q;
    assign overflow    = overflow_q;
    assign sof_err     = sof_err_q;

endmodule

// File: tb/tb_pixel_packer.sv
// tb/tb_pixel_packer.sv - directed table-driven bench for pixel_packer
module tb_pixel_packer;

    logic        wr_clk;
    logic        reset;
    logic        sof;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        fb_wr_en_in;
    logic [31:0] fb_wr_data;
    logic        fb_wr_en;
    logic        fb_wr_rdy;
    logic [17:0] word_count;
    logic        frame_done;
    logic        overflow;
    logic        sof_err;

    int n_tests = 0;
    int n_fail  = 0;
    int fd_seen = 0;

    typedef struct packed {
        logic        sof;
        logic        pv;
        logic [23:0] pd;
        logic        x_en_in;
        logic [31:0] x_data;
        logic [17:0] x_wc;
        logic        x_fd;
    } vec_t;

    vec_t vecs [0:13];

    pixel_packer #(
        .DATA_WIDTH  (32),
        .PIX_WIDTH   (24),
        .FRAME_WORDS (6),
        .FIFO_DEPTH  (4)
    ) dut (
        .wr_clk      (wr_clk),
        .reset       (reset),
        .sof         (sof),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .fb_wr_en_in (fb_wr_en_in),
        .fb_wr_data  (fb_wr_data),
        .fb_wr_en    (fb_wr_en),
        .fb_wr_rdy   (fb_wr_rdy),
        .word_count  (word_count),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .sof_err     (sof_err)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic s, logic pv, logic [23:0] pd,
                                logic en_in, logic [31:0] data, logic [17:0] wc, logic fd);
        vec_t v;
        v.sof = s; v.pv = pv; v.pd = pd;
        v.x_en_in = en_in; v.x_data = data; v.x_wc = wc; v.x_fd = fd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge wr_clk);
        #1;
        if (frame_done === 1'b1) fd_seen++;
    endtask

    task automatic drive(input logic s, input logic pv, input logic [23:0] pd);
        sof = s; pix_valid = pv; pix_data = pd;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 24'h0);
        fb_wr_en = 1'b0; fb_wr_rdy = 1'b1;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        fd_seen = 0;
    endtask

    task automatic apply_vec(input int i, input logic x_err);
        drive(vecs[i].sof, vecs[i].pv, vecs[i].pd);
        step();
        check($sformatf("vec%0d.en_in", i), {31'd0, fb_wr_en_in}, {31'd0, vecs[i].x_en_in});
        check($sformatf("vec%0d.data", i),  fb_wr_data, vecs[i].x_data);
        check($sformatf("vec%0d.wc", i),    {14'd0, word_count}, {14'd0, vecs[i].x_wc});
        check($sformatf("vec%0d.fd", i),    {31'd0, frame_done}, {31'd0, vecs[i].x_fd});
        check($sformatf("vec%0d.ovf", i),   {31'd0, overflow}, 32'd0);
        check($sformatf("vec%0d.err", i),   {31'd0, sof_err}, {31'd0, x_err});
    endtask

    logic [23:0] px [0:7];
    logic [31:0] wd [0:5];

    initial begin
        px[0] = 24'h030201; px[1] = 24'h060504; px[2] = 24'h090807; px[3] = 24'h0C0B0A;
        px[4] = 24'h0F0E0D; px[5] = 24'h121110; px[6] = 24'h151413; px[7] = 24'h181716;
        wd[0] = 32'h04030201; wd[1] = 32'h08070605; wd[2] = 32'h0C0B0A09;
        wd[3] = 32'h100F0E0D; wd[4] = 32'h14131211; wd[5] = 32'h18171615;

        vecs[0]  = mk(1'b1, 1'b0, 24'h0,     1'b1, 32'h0,        18'd0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b1, px[0],     1'b1, 32'h0,        18'd0, 1'b0);
        vecs[2]  = mk(1'b0, 1'b1, px[1],     1'b0, wd[0],        18'd0, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, px[2],     1'b0, wd[1],        18'd1, 1'b0);
        vecs[4]  = mk(1'b0, 1'b1, px[3],     1'b0, wd[2],        18'd2, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 24'h0,     1'b1, 32'h0,        18'd3, 1'b0);
        vecs[6]  = mk(1'b0, 1'b1, px[4],     1'b1, 32'h0,        18'd3, 1'b0);
        vecs[7]  = mk(1'b0, 1'b1, px[5],     1'b0, wd[3],        18'd3, 1'b0);
        vecs[8]  = mk(1'b0, 1'b1, px[6],     1'b0, wd[4],        18'd4, 1'b0);
        vecs[9]  = mk(1'b0, 1'b1, px[7],     1'b0, wd[5],        18'd5, 1'b0);
        vecs[10] = mk(1'b0, 1'b1, 24'hAABBCC, 1'b1, 32'h0,       18'd6, 1'b0);
        vecs[11] = mk(1'b0, 1'b1, 24'h112233, 1'b1, 32'h0,       18'd6, 1'b1);
        vecs[12] = mk(1'b0, 1'b0, 24'h0,     1'b1, 32'h0,        18'd6, 1'b0);
        vecs[13] = mk(1'b0, 1'b1, 24'h445566, 1'b1, 32'h0,       18'd6, 1'b0);

        reset = 1'b1;
        drive(1'b0, 1'b0, 24'h0);
        fb_wr_en = 1'b0; fb_wr_rdy = 1'b1;

        // Reset state
        do_reset();
        check("rst.en_in", {31'd0, fb_wr_en_in}, 32'd1);
        check("rst.data",  fb_wr_data, 32'd0);
        check("rst.wc",    {14'd0, word_count}, 32'd0);
        check("rst.fd",    {31'd0, frame_done}, 32'd0);
        check("rst.ovf",   {31'd0, overflow}, 32'd0);
        check("rst.err",   {31'd0, sof_err}, 32'd0);

        // Full frame of 6 words, trailing pixels ignored, single frame_done
        for (int i = 0; i < 14; i++) apply_vec(i, 1'b0);
        check("frame.fd_count", fd_seen, 32'd1);

        // Backpressure: 4 words held, later pixels dropped, then drained in order
        do_reset();
        fb_wr_rdy = 1'b0;
        drive(1'b1, 1'b0, 24'h0); step();
        for (int i = 0; i < 8; i++) begin drive(1'b0, 1'b1, px[i]); step(); end
        drive(1'b0, 1'b0, 24'h0);
        check("bp.en_in", {31'd0, fb_wr_en_in}, 32'd0);
        check("bp.ovf",   {31'd0, overflow}, 32'd1);
        check("bp.head",  fb_wr_data, wd[0]);
        check("bp.count", {29'd0, dut.u_fifo.count_o}, 32'd4);
        fb_wr_rdy = 1'b1;
        for (int k = 1; k < 4; k++) begin
            step();
            check($sformatf("bp.drain%0d", k), fb_wr_data, wd[k]);
            check($sformatf("bp.wc%0d", k), {14'd0, word_count}, k);
        end
        step();
        check("bp.empty_en_in", {31'd0, fb_wr_en_in}, 32'd1);
        check("bp.final_wc",    {14'd0, word_count}, 32'd4);

        // Full FIFO with simultaneous pop and push
        do_reset();
        fb_wr_rdy = 1'b0;
        drive(1'b1, 1'b0, 24'h0); step();
        for (int i = 0; i < 6; i++) begin drive(1'b0, 1'b1, px[i]); step(); end
        check("pp.pre_count", {29'd0, dut.u_fifo.count_o}, 32'd4);
        fb_wr_rdy = 1'b1;
        drive(1'b0, 1'b1, px[6]); step();
        drive(1'b0, 1'b0, 24'h0);
        check("pp.count", {29'd0, dut.u_fifo.count_o}, 32'd4);
        check("pp.ovf",   {31'd0, overflow}, 32'd0);
        check("pp.head",  fb_wr_data, wd[1]);
        check("pp.wc",    {14'd0, word_count}, 32'd1);
        for (int k = 2; k < 5; k++) begin
            step();
            check($sformatf("pp.drain%0d", k), fb_wr_data, wd[k]);
        end

        // sof mid-frame (with a coincident pixel) flushes and restarts packing
        do_reset();
        fb_wr_rdy = 1'b0;
        drive(1'b1, 1'b0, 24'h0); step();
        drive(1'b0, 1'b1, px[0]); step();
        drive(1'b0, 1'b1, px[1]); step();
        check("se.pre_en_in", {31'd0, fb_wr_en_in}, 32'd0);
        drive(1'b1, 1'b1, 24'hDEADBE); step();
        check("se.err",   {31'd0, sof_err}, 32'd1);
        check("se.en_in", {31'd0, fb_wr_en_in}, 32'd1);
        check("se.count", {29'd0, dut.u_fifo.count_o}, 32'd0);
        check("se.wc",    {14'd0, word_count}, 32'd0);
        fb_wr_rdy = 1'b1;
        for (int i = 1; i < 6; i++) apply_vec(i, 1'b1);

        // Reset while draining: no frame_done, outputs back to idle
        do_reset();
        for (int i = 0; i < 10; i++) apply_vec(i, 1'b0);
        fb_wr_rdy = 1'b0;
        drive(1'b0, 1'b0, 24'h0); step();
        check("rd.pre_en_in", {31'd0, fb_wr_en_in}, 32'd0);
        check("rd.pre_data",  fb_wr_data, wd[5]);
        reset = 1'b1; step(); reset = 1'b0;
        check("rd.en_in", {31'd0, fb_wr_en_in}, 32'd1);
        check("rd.wc",    {14'd0, word_count}, 32'd0);
        check("rd.data",  fb_wr_data, 32'd0);
        fb_wr_rdy = 1'b1;
        for (int k = 0; k < 3; k++) step();
        check("rd.fd_count", fd_seen, 32'd0);
        check("rd.idle_en_in", {31'd0, fb_wr_en_in}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
